// File: rtl/sram_dual_read_array_if.sv
// rtl/sram_dual_read_array_if.sv - access bus of the 1-write/2-read SRAM array
interface sram_dual_read_array_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              dev_en_n;
    logic              rd_wr;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rvalid1;
    logic              rvalid2;
    logic              ready;

    modport master (
        output dev_en_n, rd_wr, addr1, addr2, wdata,
        input  rdata1, rdata2, rvalid1, rvalid2, ready
    );

    modport slave (
        input  dev_en_n, rd_wr, addr1, addr2, wdata,
        output rdata1, rdata2, rvalid1, rvalid2, ready
    );
endinterface

// File: rtl/sram_dual_read_array.sv
// rtl/sram_dual_read_array.sv - 1-write/2-read SRAM array with registered reads and zero-fill after reset
module sram_dual_read_array #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter bit WR_BYPASS = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    sram_dual_read_array_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata2_q;
    logic              rvalid1_q;
    logic              rvalid2_q;
    logic              ready_q;

    logic              accept;
    logic              collide;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd2_next;

    assign accept  = (state == IDLE) && !bus.dev_en_n;
    assign collide = bus.rd_wr && (bus.addr2 == bus.addr1);

    // Port 2 reads the pre-write word unless bypass forwards the incoming wdata.
    assign rd2_next = (WR_BYPASS && collide) ? bus.wdata : mem[bus.addr2];

    // Single write port shared between the zero-fill sweep and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
            end else if (accept && bus.rd_wr) begin
                mem_we    = 1'b1;
                mem_waddr = bus.addr1;
                mem_wdata = bus.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            rvalid1_q <= 1'b0;
            rvalid2_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            rvalid1_q <= 1'b0;
            rvalid2_q <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        rvalid2_q <= 1'b1;
                        rdata2_q  <= rd2_next;
                        if (!bus.rd_wr) begin
                            rvalid1_q <= 1'b1;
                            rdata1_q  <= mem[bus.addr1];
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.rdata1  = rdata1_q;
    assign bus.rdata2  = rdata2_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rvalid2 = rvalid2_q;
    assign bus.ready   = ready_q;
endmodule
